// File: rtl/prescaled_tick_timer_if.sv
// Register-bus port bundle for prescaled_tick_timer: strobes, address, write data and
// combinational read data, all qualified by clk_ce.
interface prescaled_tick_timer_if;
    logic        clk_ce;
    logic        bus_write;
    logic        bus_read;
    logic [23:0] bus_address_in;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;

    modport master (
        output clk_ce, bus_write, bus_read, bus_address_in, bus_data_in,
        input  bus_data_out
    );

    modport slave (
        input  clk_ce, bus_write, bus_read, bus_address_in, bus_data_in,
        output bus_data_out
    );
endinterface

// File: rtl/prescaled_tick_timer.sv
// Tick-driven up-counter with prescaler, tap IRQs, compare match and shadowed byte reads.
// A rising edge of osc_tick steps the counter 4 clk later when clk_ce is held high.
module prescaled_tick_timer #(
    parameter int                    WIDTH     = 8,
    parameter int                    NUM_IRQS  = 4,
    parameter logic [5*NUM_IRQS-1:0] TAP_POS   = {5'd7, 5'd6, 5'd4, 5'd2},
    parameter logic [23:0]           BASE_ADDR = 24'h2040
) (
    input  logic                    clk,
    input  logic                    reset,
    prescaled_tick_timer_if.slave   bus,
    input  logic                    osc_tick,
    output logic [NUM_IRQS-1:0]     irqs,
    output logic                    irq_match
);
    localparam int NB = (WIDTH + 7) / 8;

    logic                en_q, en_d;
    logic                oneshot_q, oneshot_d;
    logic                cmpen_q, cmpen_d;
    logic [7:0]          prescale_q, prescale_d;
    logic [7:0]          psc_q, psc_d;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    cmp_q, cmp_d;
    logic [NB*8-1:0]     shadow_q, shadow_d;
    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                edge_q, edge_d;
    logic                pending_q, pending_d;
    logic [NUM_IRQS-1:0] irqs_q, irqs_d;
    logic                irq_match_q, irq_match_d;

    logic [23:0]         off;
    logic [NB*8-1:0]     cnt_pad, cmp_pad;
    logic [NB-1:0]       cnt_wr_sel, cmp_wr_sel;
    logic                wr_en, ctrl_wr, psc_wr, cnt_wr, cmp_wr, clr;
    logic                rising, consume, advance, step, match;
    logic [WIDTH-1:0]    cnt_inc;
    logic [NUM_IRQS-1:0] tap_fire;
    logic [7:0]          rd_dat;

    always_comb begin
        cnt_pad = '0;
        cmp_pad = '0;
        cnt_pad[WIDTH-1:0] = cnt_q;
        cmp_pad[WIDTH-1:0] = cmp_q;
    end

    always_comb begin
        off     = bus.bus_address_in - BASE_ADDR;
        wr_en   = bus.clk_ce & bus.bus_write;
        ctrl_wr = wr_en && (off == 24'd0);
        psc_wr  = wr_en && (off == 24'd1);
        for (int k = 0; k < NB; k++) begin
            cnt_wr_sel[k] = wr_en && (off == 24'(2 + k));
            cmp_wr_sel[k] = wr_en && (off == 24'(2 + NB + k));
        end
        cnt_wr  = |cnt_wr_sel;
        cmp_wr  = |cmp_wr_sel;
        clr     = ctrl_wr & bus.bus_data_in[1];

        rising  = sync2_q & ~edge_q;
        consume = bus.clk_ce & pending_q;
        // CLR and CNT writes pre-empt any tick consumed in the same cycle.
        advance = consume & en_q & ~clr & ~cnt_wr;
        step    = advance && (psc_q == prescale_q);
        cnt_inc = cnt_q + WIDTH'(1);
        match   = step & cmpen_q & (cnt_inc == cmp_q);

        // A tap fires when the carry ripples out of cnt[TAP_POS[i]:0].
        for (int i = 0; i < NUM_IRQS; i++) begin
            tap_fire[i] = 1'b1;
            for (int j = 0; j < WIDTH; j++) begin
                if (j <= int'(TAP_POS[5*i +: 5])) tap_fire[i] = tap_fire[i] & cnt_q[j];
            end
        end
    end

    always_comb begin
        en_d        = en_q;
        oneshot_d   = oneshot_q;
        cmpen_d     = cmpen_q;
        prescale_d  = prescale_q;
        psc_d       = psc_q;
        cnt_d       = cnt_q;
        cmp_d       = cmp_q;
        shadow_d    = shadow_q;
        sync1_d     = osc_tick;
        sync2_d     = sync1_q;
        edge_d      = sync2_q;
        pending_d   = pending_q;
        irqs_d      = irqs_q;
        irq_match_d = irq_match_q;

        if (consume) pending_d = 1'b0;
        if (rising)  pending_d = 1'b1;

        if (advance) psc_d = step ? 8'd0 : psc_q + 8'd1;
        if (step)    cnt_d = cnt_inc;

        if (match && oneshot_q) en_d = 1'b0;
        if (ctrl_wr) begin
            en_d      = bus.bus_data_in[0];
            oneshot_d = bus.bus_data_in[2];
            cmpen_d   = bus.bus_data_in[3];
        end
        if (psc_wr) prescale_d = bus.bus_data_in;

        for (int j = 0; j < WIDTH; j++) begin
            if (cnt_wr_sel[j/8]) cnt_d[j] = bus.bus_data_in[j%8];
            if (cmp_wr_sel[j/8]) cmp_d[j] = bus.bus_data_in[j%8];
        end

        if (clr || cnt_wr) begin
            psc_d     = 8'd0;
            pending_d = 1'b0;
        end
        if (clr) cnt_d = '0;

        if (bus.clk_ce && bus.bus_read && (off == 24'd2)) shadow_d = cnt_pad;

        if (bus.clk_ce) begin
            irqs_d      = step ? tap_fire : '0;
            irq_match_d = match;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q        <= 1'b0;
            oneshot_q   <= 1'b0;
            cmpen_q     <= 1'b0;
            prescale_q  <= 8'd0;
            psc_q       <= 8'd0;
            cnt_q       <= '0;
            cmp_q       <= '0;
            shadow_q    <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            edge_q      <= 1'b0;
            pending_q   <= 1'b0;
            irqs_q      <= '0;
            irq_match_q <= 1'b0;
        end else begin
            en_q        <= en_d;
            oneshot_q   <= oneshot_d;
            cmpen_q     <= cmpen_d;
            prescale_q  <= prescale_d;
            psc_q       <= psc_d;
            cnt_q       <= cnt_d;
            cmp_q       <= cmp_d;
            shadow_q    <= shadow_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            edge_q      <= edge_d;
            pending_q   <= pending_d;
            irqs_q      <= irqs_d;
            irq_match_q <= irq_match_d;
        end
    end

    // Byte 0 of CNT is always live; the upper bytes come from the shadow.
    always_comb begin
        rd_dat = 8'd0;
        if (off == 24'd0) rd_dat = {4'd0, cmpen_q, oneshot_q, 1'b0, en_q};
        if (off == 24'd1) rd_dat = prescale_q;
        for (int k = 0; k < NB; k++) begin
            if (off == 24'(2 + k))      rd_dat = (k == 0) ? cnt_pad[7:0] : shadow_q[8*k +: 8];
            if (off == 24'(2 + NB + k)) rd_dat = cmp_pad[8*k +: 8];
        end
    end

    assign bus.bus_data_out = rd_dat;
    assign irqs             = irqs_q;
    assign irq_match        = irq_match_q;
endmodule

// File: tb/tb_prescaled_tick_timer.sv
// Directed bench for prescaled_tick_timer: an 8-bit and a 16-bit instance share clock and reset.
module tb_prescaled_tick_timer;
    localparam logic [23:0] BASE = 24'h2040;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       osc8 = 1'b0, osc16 = 1'b0;
    logic [3:0] irqs8, irqs16;
    logic       m8, m16;

    int checks = 0;
    int errors = 0;
    int n8 [4] = '{default: 0};
    int nm8 = 0;

    always #5 clk = ~clk;

    prescaled_tick_timer_if b8 ();
    prescaled_tick_timer_if b16 ();

    prescaled_tick_timer #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .bus(b8), .osc_tick(osc8), .irqs(irqs8), .irq_match(m8)
    );
    prescaled_tick_timer #(.WIDTH(16)) u16 (
        .clk(clk), .reset(reset), .bus(b16), .osc_tick(osc16), .irqs(irqs16), .irq_match(m16)
    );

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (irqs8[i] === 1'b1) n8[i]++;
        if (m8 === 1'b1) nm8++;
    end

    task automatic wr(input bit s16, input logic [23:0] a, input logic [7:0] d);
        @(negedge clk);
        if (s16) begin
            b16.bus_address_in = a; b16.bus_data_in = d; b16.bus_write = 1'b1;
        end else begin
            b8.bus_address_in = a; b8.bus_data_in = d; b8.bus_write = 1'b1;
        end
        @(negedge clk);
        b8.bus_write = 1'b0;
        b16.bus_write = 1'b0;
    endtask

    task automatic rd(input bit s16, input logic [23:0] a, input bit strobe, output logic [7:0] d);
        @(negedge clk);
        if (s16) begin
            b16.bus_address_in = a; b16.bus_read = strobe;
        end else begin
            b8.bus_address_in = a; b8.bus_read = strobe;
        end
        #1 d = s16 ? b16.bus_data_out : b8.bus_data_out;
        @(negedge clk);
        b8.bus_read = 1'b0;
        b16.bus_read = 1'b0;
    endtask

    task automatic tick(input bit s16, input int n);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            if (s16) osc16 = 1'b1; else osc8 = 1'b1;
            repeat (4) @(negedge clk);
            if (s16) osc16 = 1'b0; else osc8 = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        logic [7:0] d;
        checks++;
        if (irqs8 !== 4'h0 || m8 !== 1'b0 || irqs16 !== 4'h0 || m16 !== 1'b0) begin
            errors++;
            $display("FAIL reset_irqs: got irqs8=%h m8=%b irqs16=%h m16=%b, want all 0", irqs8, m8, irqs16, m16);
        end
        for (int a = 0; a < 5; a++) begin
            rd(0, BASE + 24'(a), 0, d);
            checks++;
            if (d !== 8'h00) begin
                errors++;
                $display("FAIL reset_read8 off %0d: got %h want 00", a, d);
            end
        end
        for (int a = 0; a < 7; a++) begin
            rd(1, BASE + 24'(a), 0, d);
            checks++;
            if (d !== 8'h00) begin
                errors++;
                $display("FAIL reset_read16 off %0d: got %h want 00", a, d);
            end
        end
    endtask

    task automatic test_regs;
        logic [7:0] d;
        wr(0, BASE, 8'hF0);
        rd(0, BASE, 0, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL ctrl_hi_bits: got %h want 00", d); end
        wr(0, BASE, 8'h0D);
        rd(0, BASE, 0, d);
        checks++;
        if (d !== 8'h0D) begin errors++; $display("FAIL ctrl_fields: got %h want 0d", d); end
        wr(0, BASE, 8'h02);
        rd(0, BASE, 0, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL ctrl_clr_reads0: got %h want 00", d); end
        wr(0, BASE + 24'd1, 8'hA5);
        rd(0, BASE + 24'd1, 0, d);
        checks++;
        if (d !== 8'hA5) begin errors++; $display("FAIL prescale_rw: got %h want a5", d); end
        wr(0, BASE + 24'd3, 8'h3C);
        rd(0, BASE + 24'd3, 0, d);
        checks++;
        if (d !== 8'h3C) begin errors++; $display("FAIL cmp_rw: got %h want 3c", d); end
        wr(0, BASE + 24'd1, 8'h00);
    endtask

    task automatic test_wrap;
        logic [7:0] d;
        int s[4];
        int sm;
        wr(0, BASE, 8'h02);
        wr(0, BASE, 8'h01);
        for (int i = 0; i < 4; i++) s[i] = n8[i];
        sm = nm8;
        tick(0, 255);
        rd(0, BASE + 24'd2, 0, d);
        checks++;
        if (d !== 8'hFF) begin errors++; $display("FAIL wrap_cnt255: got %h want ff", d); end
        checks++;
        if (n8[0]-s[0] != 31 || n8[1]-s[1] != 7 || n8[2]-s[2] != 1 || n8[3]-s[3] != 0) begin
            errors++;
            $display("FAIL wrap_irqs255: got %0d %0d %0d %0d want 31 7 1 0",
                     n8[0]-s[0], n8[1]-s[1], n8[2]-s[2], n8[3]-s[3]);
        end
        tick(0, 1);
        rd(0, BASE + 24'd2, 0, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL wrap_cnt0: got %h want 00", d); end
        checks++;
        if (n8[0]-s[0] != 32 || n8[1]-s[1] != 8 || n8[2]-s[2] != 2 || n8[3]-s[3] != 1 || nm8 != sm) begin
            errors++;
            $display("FAIL wrap_irqs256: got %0d %0d %0d %0d match %0d want 32 8 2 1 match 0",
                     n8[0]-s[0], n8[1]-s[1], n8[2]-s[2], n8[3]-s[3], nm8-sm);
        end
    endtask

    task automatic test_prescale;
        logic [7:0] d;
        wr(0, BASE, 8'h02);
        wr(0, BASE + 24'd1, 8'h03);
        wr(0, BASE, 8'h01);
        tick(0, 8);
        rd(0, BASE + 24'd2, 0, d);
        checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL psc_8ticks: got %h want 02", d); end
        tick(0, 3);
        rd(0, BASE + 24'd2, 0, d);
        checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL psc_11ticks: got %h want 02", d); end
        tick(0, 1);
        rd(0, BASE + 24'd2, 0, d);
        checks++;
        if (d !== 8'h03) begin errors++; $display("FAIL psc_12ticks: got %h want 03", d); end
        wr(0, BASE + 24'd1, 8'h00);
    endtask

    task automatic test_oneshot;
        logic [7:0] d;
        int sm;
        wr(0, BASE, 8'h02);
        wr(0, BASE + 24'd3, 8'h05);
        wr(0, BASE, 8'h0D);
        sm = nm8;
        tick(0, 4);
        checks++;
        if (nm8 - sm != 0) begin errors++; $display("FAIL match_early: got %0d want 0", nm8 - sm); end
        tick(0, 1);
        checks++;
        if (nm8 - sm != 1) begin errors++; $display("FAIL match_at5: got %0d want 1", nm8 - sm); end
        rd(0, BASE, 0, d);
        checks++;
        if (d !== 8'h0C) begin errors++; $display("FAIL oneshot_en: got %h want 0c", d); end
        tick(0, 5);
        rd(0, BASE + 24'd2, 0, d);
        checks++;
        if (d !== 8'h05 || nm8 - sm != 1) begin
            errors++;
            $display("FAIL oneshot_hold: got cnt %h matches %0d want 05 and 1", d, nm8 - sm);
        end
    endtask

    task automatic test_clr_tick;
        logic [7:0] d;
        int s[4];
        wr(0, BASE, 8'h01);
        wr(0, BASE + 24'd2, 8'hFF);
        for (int i = 0; i < 4; i++) s[i] = n8[i];
        @(negedge clk);
        osc8 = 1'b1;
        repeat (3) @(negedge clk);
        b8.bus_address_in = BASE; b8.bus_data_in = 8'h03; b8.bus_write = 1'b1;
        @(negedge clk);
        b8.bus_write = 1'b0;
        osc8 = 1'b0;
        repeat (4) @(negedge clk);
        rd(0, BASE + 24'd2, 0, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL clr_tick_cnt: got %h want 00", d); end
        checks++;
        if (n8[0] != s[0] || n8[1] != s[1] || n8[2] != s[2] || n8[3] != s[3]) begin
            errors++;
            $display("FAIL clr_tick_irq: got %0d %0d %0d %0d new pulses want 0",
                     n8[0]-s[0], n8[1]-s[1], n8[2]-s[2], n8[3]-s[3]);
        end
        tick(0, 1);
        rd(0, BASE + 24'd2, 0, d);
        checks++;
        if (d !== 8'h01) begin errors++; $display("FAIL clr_then_tick: got %h want 01", d); end
    endtask

    task automatic test_shadow;
        logic [7:0] d;
        wr(1, BASE, 8'h01);
        wr(1, BASE + 24'd2, 8'hFF);
        wr(1, BASE + 24'd3, 8'h00);
        rd(1, BASE + 24'd2, 1, d);
        checks++;
        if (d !== 8'hFF) begin errors++; $display("FAIL shadow_b0: got %h want ff", d); end
        tick(1, 1);
        rd(1, BASE + 24'd3, 0, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL shadow_b1: got %h want 00", d); end
        rd(1, BASE + 24'd2, 1, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL live_b0: got %h want 00", d); end
        rd(1, BASE + 24'd3, 0, d);
        checks++;
        if (d !== 8'h01) begin errors++; $display("FAIL relatched_b1: got %h want 01", d); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        wr(0, BASE, 8'h01);
        wr(0, BASE + 24'd2, 8'h7F);
        @(negedge clk);
        b8.bus_address_in = BASE + 24'd2;
        osc8 = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (irqs8 !== 4'b0111 || b8.bus_data_out !== 8'h80) begin
            errors++;
            $display("FAIL pre_reset: got irqs %b cnt %h want 0111 80", irqs8, b8.bus_data_out);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (irqs8 !== 4'h0 || m8 !== 1'b0 || b8.bus_data_out !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got irqs %b match %b cnt %h want 0 0 00", irqs8, m8, b8.bus_data_out);
        end
        osc8 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rd(0, BASE, 0, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h want 00", d); end
        tick(0, 1);
        rd(0, BASE + 24'd2, 0, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL reset_no_count: got %h want 00", d); end
    endtask

    initial begin
        b8.clk_ce = 1'b1;  b8.bus_write = 1'b0;  b8.bus_read = 1'b0;
        b8.bus_address_in = '0;  b8.bus_data_in = '0;
        b16.clk_ce = 1'b1; b16.bus_write = 1'b0; b16.bus_read = 1'b0;
        b16.bus_address_in = '0; b16.bus_data_in = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset;
        test_regs;
        test_wrap;
        test_prescale;
        test_oneshot;
        test_clr_tick;
        test_shadow;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/prescaled_tick_timer.md
# prescaled_tick_timer

Parametrised tick-driven up-counter for the system-register bus: generalised counter width, programmable prescaler, configurable IRQ tap bits, compare-match interrupt with one-shot mode, and tear-free multi-byte counter reads. A slow oscillator level (e.g. the 256 Hz source) is synchronised into the single core clock domain. Sits beside the other timer blocks on the 24-bit register bus and feeds the IRQ controller.

## Interface
- WIDTH, 8: counter width in bits, 8..32; NB = ceil(WIDTH/8) counter bytes.
- NUM_IRQS, 4: number of tap interrupts, 1..8.
- TAP_POS, {5'd7,5'd6,5'd4,5'd2}: packed 5-bit tap indices; entry i sits at bits [5i+4:5i], each < WIDTH.
- BASE_ADDR, 24'h2040: address of CTRL.
- clk  input  1  core clock; all state is on posedge.
- reset  input  1  asynchronous, active-high; clears all state.
- clk_ce  input  1  clock enable qualifying bus accesses, counting and IRQ updates.
- bus_write  input  1  write strobe.
- bus_read  input  1  read strobe; used only for the shadow latch.
- bus_address_in  input  24  register address.
- bus_data_in  input  8  write data.
- bus_data_out  output  8  combinational read data; 0 for unmapped addresses.
- osc_tick  input  1  asynchronous slow oscillator level; each rising edge is one tick.
- irqs  output  NUM_IRQS  tap interrupt pulses.
- irq_match  output  1  compare-match interrupt pulse.

## Operation
- Register map, offsets from BASE_ADDR:
  - +0 CTRL: bit0 EN, bit1 CLR (write-1 action, reads 0), bit2 ONESHOT, bit3 CMPEN; bits 7:4 read 0.
  - +1 PRESCALE: 8 bits.
  - +2..+1+NB CNT: little-endian.
  - +2+NB..+1+2NB CMP: little-endian.
  - Bits at or above WIDTH in the top byte read 0 and ignore writes.
- Bus write: takes effect on the posedge where clk_ce && bus_write.
- Tick path: 2-flop synchroniser, then an edge-detect flop. A rising edge sets `pending` on every clk, ungated. `pending` is consumed on the next clk_ce cycle.
- Consuming a tick with EN=1:
  - If psc == PRESCALE: psc <= 0 and the counter steps.
  - Otherwise psc <= psc+1.
- With EN=0, pending ticks are discarded and psc holds its value.
- Counter step: cnt <= cnt+1 mod 2^WIDTH.
  - irqs[i] fires if cnt[TAP_POS[i]:0] was all ones before the step, i.e. the carry leaves tap i.
  - At wrap (all ones to 0), every tap fires.
- Match: on a step where the new cnt == CMP and CMPEN=1, irq_match fires. If ONESHOT=1, EN is cleared in the same cycle.
- CLR: cnt, psc and `pending` are zeroed at the write edge. No IRQ is generated.
- CNT byte write: loads that byte directly, and zeroes psc and `pending`. No IRQ is generated.
- Shadow read: bus_read && clk_ce at CNT byte 0 latches bytes 1..NB-1 into the shadow. Reads of CNT bytes 1..NB-1 return the shadow. Byte 0 always reads live.
- Priority within one clk_ce cycle: reset > CLR > CNT write > tick step. The CTRL EN write value overrides the one-shot clear.

## Timing
- Reset values: CTRL, PRESCALE, CNT, CMP, shadow, psc, synchroniser, pending all 0; irqs=0, irq_match=0.
- irqs and irq_match are registered. They are set on the step edge and cleared at the next clk_ce edge, so each pulse lasts exactly one clk_ce period.
- Tick latency with clk_ce held high: osc_tick rises, `pending` is set 3 clk later, and cnt/IRQ update on the following clk. Total 4 clk.
- With clk_ce gated, the step occurs on the first clk_ce edge after `pending` is set. At most one pending tick is held; extra edges are merged.
- Reads are combinational in the same cycle. The shadow updates at the clk_ce edge of the byte-0 read.
- Reset asserted mid-count clears everything immediately. The first tick is counted only after reset deasserts and a fresh rising edge of osc_tick is synchronised.

## Test plan
- Reset, then read all addresses: all return 0; irqs=0, irq_match=0.
- WIDTH=8, PRESCALE=0, EN=1, 256 ticks: cnt returns to 0. irqs[0] fires 32 times, irqs[1] 8 times, irqs[2] 2 times, irqs[3] once, at the step 255 -> 0.
- PRESCALE=3, EN=1, 8 ticks: cnt=2; psc=0 after tick 8.
- CMP=5, CMPEN=1, ONESHOT=1, EN=1, 10 ticks: irq_match fires once, at the step to 5; EN reads 0; cnt stays 5.
- WIDTH=16, cnt=0x00FF: read byte 0, then deliver one tick, then read byte 1. Byte 0 reads 0xFF; byte 1 reads 0x00 from the shadow; live cnt=0x0100.
- CLR write in the same clk_ce cycle as a consumed tick: cnt=0, no IRQ. Reset asserted mid-count: all outputs 0 asynchronously.
